branch_predict_unit: RTL and testbench



---
 rtl/branch_predict_unit.sv | 100 ++++++++++
 tb/tb_branch_predict_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB with 2-bit saturating counters plus the decode-stage
// branch resolution path: zero-latency fetch lookup, registered flush/redirect.
module branch_predict_unit #(
    parameter int PC_WIDTH  = 32,
    parameter int IDX_BITS  = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_f_valid,
    input  logic [PC_WIDTH-1:0]  i_f_pc,
    output logic                 o_f_hit,
    output logic                 o_f_taken,
    output logic [PC_WIDTH-1:0]  o_f_target,
    input  logic                 i_r_valid,
    input  logic [PC_WIDTH-1:0]  i_r_pc,
    input  logic                 i_r_taken,
    input  logic [PC_WIDTH-1:0]  i_r_target,
    input  logic                 i_r_pred_taken,
    input  logic [PC_WIDTH-1:0]  i_r_pred_target,
    output logic                 o_flush,
    output logic [PC_WIDTH-1:0]  o_redirect_pc,
    output logic [CNT_WIDTH-1:0] o_branch_cnt,
    output logic [CNT_WIDTH-1:0] o_mispred_cnt
);
    localparam int ENTRIES = 2 ** IDX_BITS;
    localparam int TAG_W   = PC_WIDTH - IDX_BITS - 2;

    typedef struct packed {
        logic                valid;
        logic [TAG_W-1:0]    tag;
        logic [1:0]          ctr;
        logic [PC_WIDTH-1:0] target;
    } btb_entry_t;

    btb_entry_t btb [ENTRIES];

    logic [IDX_BITS-1:0] f_idx, r_idx;
    logic [TAG_W-1:0]    f_tag, r_tag;
    btb_entry_t          f_ent, r_ent;
    logic                r_hit, mispred;
    logic                unused_pc_bits;

    assign f_idx = i_f_pc[IDX_BITS+1:2];
    assign f_tag = i_f_pc[PC_WIDTH-1:IDX_BITS+2];
    assign r_idx = i_r_pc[IDX_BITS+1:2];
    assign r_tag = i_r_pc[PC_WIDTH-1:IDX_BITS+2];
    assign unused_pc_bits = ^{i_f_pc[1:0], i_r_pc[1:0]};

    assign f_ent      = btb[f_idx];
    assign o_f_hit    = i_f_valid & f_ent.valid & (f_ent.tag == f_tag);
    assign o_f_taken  = o_f_hit & f_ent.ctr[1];
    assign o_f_target = o_f_taken ? f_ent.target : '0;

    assign r_ent   = btb[r_idx];
    assign r_hit   = r_ent.valid & (r_ent.tag == r_tag);
    assign mispred = (i_r_taken != i_r_pred_taken) |
                     (i_r_taken & i_r_pred_taken & (i_r_target != i_r_pred_target));

    // Table update; lookup sees the new entry only from the next cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < ENTRIES; i++) btb[i] <= '0;
        end else if (i_r_valid) begin
            if (r_hit) begin
                if (i_r_taken) begin
                    if (r_ent.ctr != 2'b11) btb[r_idx].ctr <= r_ent.ctr + 2'd1;
                    btb[r_idx].target <= i_r_target;
                end else if (r_ent.ctr != 2'b00) begin
                    btb[r_idx].ctr <= r_ent.ctr - 2'd1;
                end
            end else if (i_r_taken) begin
                btb[r_idx].valid  <= 1'b1;
                btb[r_idx].tag    <= r_tag;
                btb[r_idx].ctr    <= 2'b10;
                btb[r_idx].target <= i_r_target;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_flush       <= 1'b0;
            o_redirect_pc <= '0;
            o_branch_cnt  <= '0;
            o_mispred_cnt <= '0;
        end else begin
            o_flush <= i_r_valid & mispred;
            if (i_r_valid) begin
                if (mispred)
                    o_redirect_pc <= i_r_taken ? i_r_target : i_r_pc + PC_WIDTH'(4);
                if (o_branch_cnt != '1)
                    o_branch_cnt <= o_branch_cnt + CNT_WIDTH'(1);
                if (mispred && o_mispred_cnt != '1)
                    o_mispred_cnt <= o_mispred_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: default instance plus a CNT_WIDTH=4
// instance sharing stimulus for the saturation checks.
module tb_branch_predict_unit;
    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_f_valid;
    logic [31:0] i_f_pc;
    logic        i_r_valid, i_r_taken, i_r_pred_taken;
    logic [31:0] i_r_pc, i_r_target, i_r_pred_target;

    logic        o_f_hit, o_f_taken, o_flush;
    logic [31:0] o_f_target, o_redirect_pc;
    logic [15:0] o_branch_cnt, o_mispred_cnt;

    logic        s_hit, s_taken, s_flush;
    logic [31:0] s_target, s_redirect;
    logic [3:0]  s_branch_cnt, s_mispred_cnt;

    int tests = 0;
    int fails = 0;

    always #5 i_clk = ~i_clk;

    branch_predict_unit dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_f_valid(i_f_valid), .i_f_pc(i_f_pc),
        .o_f_hit(o_f_hit), .o_f_taken(o_f_taken), .o_f_target(o_f_target),
        .i_r_valid(i_r_valid), .i_r_pc(i_r_pc), .i_r_taken(i_r_taken),
        .i_r_target(i_r_target), .i_r_pred_taken(i_r_pred_taken),
        .i_r_pred_target(i_r_pred_target),
        .o_flush(o_flush), .o_redirect_pc(o_redirect_pc),
        .o_branch_cnt(o_branch_cnt), .o_mispred_cnt(o_mispred_cnt)
    );

    branch_predict_unit #(.CNT_WIDTH(4)) dut_small (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_f_valid(i_f_valid), .i_f_pc(i_f_pc),
        .o_f_hit(s_hit), .o_f_taken(s_taken), .o_f_target(s_target),
        .i_r_valid(i_r_valid), .i_r_pc(i_r_pc), .i_r_taken(i_r_taken),
        .i_r_target(i_r_target), .i_r_pred_taken(i_r_pred_taken),
        .i_r_pred_target(i_r_pred_target),
        .o_flush(s_flush), .o_redirect_pc(s_redirect),
        .o_branch_cnt(s_branch_cnt), .o_mispred_cnt(s_mispred_cnt)
    );

    // Presents one resolve for a single edge; returns at posedge+1.
    task automatic resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                           input logic ptk, input logic [31:0] ptgt);
        i_r_valid = 1'b1; i_r_pc = pc; i_r_taken = tk; i_r_target = tgt;
        i_r_pred_taken = ptk; i_r_pred_target = ptgt;
        @(posedge i_clk); #1;
        i_r_valid = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] pc, input logic eh, input logic et,
                          input logic [31:0] etgt, input string nm);
        i_f_valid = 1'b1; i_f_pc = pc; #1;
        tests++;
        if ({o_f_hit, o_f_taken, o_f_target} !== {eh, et, etgt}) begin
            fails++;
            $display("FAIL %s: got hit=%0b taken=%0b tgt=%h, want hit=%0b taken=%0b tgt=%h",
                     nm, o_f_hit, o_f_taken, o_f_target, eh, et, etgt);
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_f_valid = 1'b0; i_f_pc = '0; i_r_valid = 1'b0;
        i_r_pc = '0; i_r_taken = 1'b0; i_r_target = '0;
        i_r_pred_taken = 1'b0; i_r_pred_target = '0;
        repeat (2) @(posedge i_clk);
        #1;
        lookup(32'h40, 1'b0, 1'b0, 32'h0, "reset_lookup");
        tests++;
        if ({o_flush, o_redirect_pc, o_branch_cnt, o_mispred_cnt} !== '0) begin
            fails++;
            $display("FAIL reset_regs: got flush=%0b redir=%h br=%0d mp=%0d, want all 0",
                     o_flush, o_redirect_pc, o_branch_cnt, o_mispred_cnt);
        end
        i_rst = 1'b0;
        @(posedge i_clk); #1;
    endtask

    task automatic test_allocate();
        // Same-cycle lookup of the written index returns the old (empty) entry.
        i_f_valid = 1'b1; i_f_pc = 32'h40;
        i_r_valid = 1'b1; i_r_pc = 32'h40; i_r_taken = 1'b1; i_r_target = 32'h80;
        i_r_pred_taken = 1'b0; i_r_pred_target = 32'h0;
        #1;
        tests++;
        if (o_f_hit !== 1'b0) begin
            fails++; $display("FAIL no_bypass: got hit=%0b want 0", o_f_hit);
        end
        @(posedge i_clk); #1;
        i_r_valid = 1'b0;
        tests++;
        if ({o_flush, o_redirect_pc} !== {1'b1, 32'h80}) begin
            fails++; $display("FAIL alloc_flush: got %0b/%h want 1/00000080", o_flush, o_redirect_pc);
        end
        lookup(32'h40, 1'b1, 1'b1, 32'h80, "alloc_lookup");
        tests++;
        if ({o_branch_cnt, o_mispred_cnt} !== {16'd1, 16'd1}) begin
            fails++; $display("FAIL alloc_cnt: got br=%0d mp=%0d want 1/1", o_branch_cnt, o_mispred_cnt);
        end
        @(posedge i_clk); #1;
        tests++;
        if (o_flush !== 1'b0) begin
            fails++; $display("FAIL flush_pulse: got %0b want 0", o_flush);
        end
    endtask

    task automatic test_not_taken();
        resolve(32'h40, 1'b0, 32'h0, 1'b0, 32'h0);  // 10 -> 01
        lookup(32'h40, 1'b1, 1'b0, 32'h0, "nt_weak");
        tests++;
        if (o_flush !== 1'b0) begin
            fails++; $display("FAIL nt_noflush: got %0b want 0", o_flush);
        end
        resolve(32'h40, 1'b0, 32'h0, 1'b0, 32'h0);  // 01 -> 00
        resolve(32'h40, 1'b0, 32'h0, 1'b0, 32'h0);  // stays 00
        resolve(32'h40, 1'b1, 32'h80, 1'b1, 32'h80); // 00 -> 01
        lookup(32'h40, 1'b1, 1'b0, 32'h0, "nt_sat_low_a");
        resolve(32'h40, 1'b1, 32'h80, 1'b1, 32'h80); // 01 -> 10
        lookup(32'h40, 1'b1, 1'b1, 32'h80, "nt_sat_low_b");
        resolve(32'h40, 1'b0, 32'h0, 1'b1, 32'h80);  // mispredict, fall through
        tests++;
        if ({o_flush, o_redirect_pc} !== {1'b1, 32'h44}) begin
            fails++; $display("FAIL nt_redirect: got %0b/%h want 1/00000044", o_flush, o_redirect_pc);
        end
        tests++;
        if ({o_branch_cnt, o_mispred_cnt} !== {16'd7, 16'd2}) begin
            fails++; $display("FAIL nt_cnt: got br=%0d mp=%0d want 7/2", o_branch_cnt, o_mispred_cnt);
        end
    endtask

    task automatic test_alias();
        resolve(32'h440, 1'b1, 32'h500, 1'b1, 32'h500);
        lookup(32'h40, 1'b0, 1'b0, 32'h0, "alias_old");
        lookup(32'h440, 1'b1, 1'b1, 32'h500, "alias_new");
    endtask

    task automatic test_target_mispred();
        resolve(32'h440, 1'b1, 32'h80, 1'b1, 32'h84);
        tests++;
        if ({o_flush, o_redirect_pc} !== {1'b1, 32'h80}) begin
            fails++; $display("FAIL tgt_redirect: got %0b/%h want 1/00000080", o_flush, o_redirect_pc);
        end
        resolve(32'h440, 1'b1, 32'h80, 1'b1, 32'h80);
        tests++;
        if ({o_flush, o_branch_cnt, o_mispred_cnt} !== {1'b0, 16'd10, 16'd3}) begin
            fails++; $display("FAIL correct_pred: got flush=%0b br=%0d mp=%0d want 0/10/3",
                              o_flush, o_branch_cnt, o_mispred_cnt);
        end
    endtask

    task automatic test_back_to_back();
        i_r_valid = 1'b1; i_r_pc = 32'h100; i_r_taken = 1'b1; i_r_target = 32'h200;
        i_r_pred_taken = 1'b0; i_r_pred_target = 32'h0;
        @(posedge i_clk); #1;
        tests++;
        if ({o_flush, o_redirect_pc} !== {1'b1, 32'h200}) begin
            fails++; $display("FAIL b2b_first: got %0b/%h want 1/00000200", o_flush, o_redirect_pc);
        end
        i_r_pc = 32'hFFFF_FFFC; i_r_taken = 1'b0; i_r_pred_taken = 1'b1;
        @(posedge i_clk); #1;
        i_r_valid = 1'b0;
        tests++;
        if ({o_flush, o_redirect_pc} !== {1'b1, 32'h0}) begin
            fails++; $display("FAIL b2b_wrap: got %0b/%h want 1/00000000", o_flush, o_redirect_pc);
        end
        @(posedge i_clk); #1;
        tests++;
        if (o_flush !== 1'b0) begin
            fails++; $display("FAIL b2b_end: got %0b want 0", o_flush);
        end
    endtask

    task automatic test_idle();
        i_r_valid = 1'b0; i_r_pc = 32'h300; i_r_taken = 1'b1; i_r_target = 32'h400;
        i_r_pred_taken = 1'b0;
        @(posedge i_clk); #1;
        tests++;
        if ({o_flush, o_branch_cnt, o_mispred_cnt} !== {1'b0, 16'd12, 16'd5}) begin
            fails++; $display("FAIL idle: got flush=%0b br=%0d mp=%0d want 0/12/5",
                              o_flush, o_branch_cnt, o_mispred_cnt);
        end
        lookup(32'h300, 1'b0, 1'b0, 32'h0, "idle_lookup");
    endtask

    task automatic test_saturation();
        i_rst = 1'b1; #1; i_rst = 1'b0;
        i_r_valid = 1'b1; i_r_pc = 32'h100; i_r_taken = 1'b1; i_r_target = 32'h200;
        i_r_pred_taken = 1'b0; i_r_pred_target = 32'h0;
        repeat (20) @(posedge i_clk);
        #1;
        i_r_valid = 1'b0;
        tests++;
        if ({s_branch_cnt, s_mispred_cnt} !== {4'd15, 4'd15}) begin
            fails++; $display("FAIL sat_small: got br=%0d mp=%0d want 15/15", s_branch_cnt, s_mispred_cnt);
        end
        tests++;
        if ({o_branch_cnt, o_mispred_cnt} !== {16'd20, 16'd20}) begin
            fails++; $display("FAIL sat_big: got br=%0d mp=%0d want 20/20", o_branch_cnt, o_mispred_cnt);
        end
        tests++;
        if ({o_flush, s_flush} !== 2'b11) begin
            fails++; $display("FAIL sat_flush: got %0b%0b want 11", o_flush, s_flush);
        end
        i_rst = 1'b1; #1;
        tests++;
        if ({o_flush, s_flush, o_redirect_pc, o_branch_cnt, o_mispred_cnt, s_branch_cnt} !== '0) begin
            fails++; $display("FAIL rst_midflush: got flush=%0b%0b redir=%h br=%0d mp=%0d sbr=%0d want 0",
                              o_flush, s_flush, o_redirect_pc, o_branch_cnt, o_mispred_cnt, s_branch_cnt);
        end
        lookup(32'h100, 1'b0, 1'b0, 32'h0, "rst_lookup");
        @(posedge i_clk); #1;
        i_rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_allocate();
        test_not_taken();
        test_alias();
        test_target_mispred();
        test_back_to_back();
        test_idle();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
